// File: rtl/axi4_cmd_arbiter.sv
// Round-robin scheduler for two clients sharing the AXI4 master's simple command port.
// A request is latched in IDLE, pulsed to the master in ISSUE, then held until m_done or timeout.
module axi4_cmd_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int LEN_W   = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              m_axi_aclk,
   input  logic              m_axi_aresetn,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [LEN_W-1:0]  len0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LEN_W-1:0]  len1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic              write,
   output logic [ADDR_W-1:0] write_address,
   output logic [LEN_W-1:0]  write_burstlen,
   output logic [DATA_W-1:0] write_data,
   output logic              read,
   output logic [ADDR_W-1:0] read_address,
   output logic [LEN_W-1:0]  read_burstlen,
   input  logic              m_done,
   output logic              busy
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_n;
   logic              last_grant, last_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              gnt0_n, gnt1_n, done0_n, done1_n, err0_n, err1_n;
   logic              write_n, read_n, busy_n;
   logic [ADDR_W-1:0] wa_n, ra_n;
   logic [LEN_W-1:0]  wl_n, rl_n;
   logic [DATA_W-1:0] wd_n;

   logic              sel0, sel1, expire;
   logic              s_we;
   logic [ADDR_W-1:0] s_addr;
   logic [LEN_W-1:0]  s_len;
   logic [DATA_W-1:0] s_data;

   // On a tie the requester that did not win last time goes next.
   assign sel0   = req0 & (~req1 | last_grant);
   assign sel1   = req1 & (~req0 | ~last_grant);
   assign s_we   = sel1 ? we1    : we0;
   assign s_addr = sel1 ? addr1  : addr0;
   assign s_len  = sel1 ? len1   : len0;
   assign s_data = sel1 ? wdata1 : wdata0;
   // cnt counts completed WAIT cycles; expiry after TIMEOUT of them.
   assign expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_n = state;
      last_n  = last_grant;
      cnt_n   = cnt;
      gnt0_n  = 1'b0;
      gnt1_n  = 1'b0;
      done0_n = 1'b0;
      done1_n = 1'b0;
      err0_n  = 1'b0;
      err1_n  = 1'b0;
      write_n = 1'b0;
      read_n  = 1'b0;
      busy_n  = busy;
      wa_n    = write_address;
      wl_n    = write_burstlen;
      wd_n    = write_data;
      ra_n    = read_address;
      rl_n    = read_burstlen;
      case (state)
         IDLE: begin
            if (sel0 | sel1) begin
               state_n = ISSUE;
               last_n  = sel1;
               gnt0_n  = sel0;
               gnt1_n  = sel1;
               busy_n  = 1'b1;
               write_n = s_we;
               read_n  = ~s_we;
               wa_n    = s_we ? s_addr : '0;
               wl_n    = s_we ? s_len  : '0;
               wd_n    = s_we ? s_data : '0;
               ra_n    = s_we ? '0 : s_addr;
               rl_n    = s_we ? '0 : s_len;
            end
         end
         ISSUE: begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         WAIT: begin
            cnt_n = cnt + 1'b1;
            if (m_done | expire) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               done0_n = ~last_grant;
               done1_n = last_grant;
               err0_n  = ~m_done & ~last_grant;
               err1_n  = ~m_done & last_grant;
               wa_n    = '0;
               wl_n    = '0;
               wd_n    = '0;
               ra_n    = '0;
               rl_n    = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         cnt            <= '0;
         gnt0           <= 1'b0;
         gnt1           <= 1'b0;
         done0          <= 1'b0;
         done1          <= 1'b0;
         err0           <= 1'b0;
         err1           <= 1'b0;
         write          <= 1'b0;
         read           <= 1'b0;
         busy           <= 1'b0;
         write_address  <= '0;
         write_burstlen <= '0;
         write_data     <= '0;
         read_address   <= '0;
         read_burstlen  <= '0;
      end else begin
         state          <= state_n;
         last_grant     <= last_n;
         cnt            <= cnt_n;
         gnt0           <= gnt0_n;
         gnt1           <= gnt1_n;
         done0          <= done0_n;
         done1          <= done1_n;
         err0           <= err0_n;
         err1           <= err1_n;
         write          <= write_n;
         read           <= read_n;
         busy           <= busy_n;
         write_address  <= wa_n;
         write_burstlen <= wl_n;
         write_data     <= wd_n;
         read_address   <= ra_n;
         read_burstlen  <= rl_n;
      end
   end
endmodule
